// File: rtl/sec_decoder_awe_28b_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sec_decoder_awe_28b_seq
//  Purpose  : Sequential single-error-correcting decoder for a 36-bit codeword
//             (28 data bits + 8 check bits). The syndrome is computed on the
//             load edge, then the 36 single-bit error candidates are walked one
//             per clock until one matches. The result is held with 'found'.
//  Ports    : clk    - clock, all state on posedge
//             rst_n  - asynchronous active-low reset
//             W      - received codeword {C[7:0], D[27:0]}, level input
//             found  - high when N is valid, held until the next load
//             N      - {uncorrectable, corrected data[27:0]}
//  Revision : 1.0 - initial release
// ============================================================================
module sec_decoder_awe_28b_seq #(
  parameter int W_BITS = 36,
  parameter int N_BITS = 29,
  parameter int D_BITS = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_BITS-1:0] W,
  output logic              found,
  output logic [N_BITS-1:0] N
);

  localparam int         C_CHK_BITS = W_BITS - D_BITS;
  localparam logic [5:0] C_LAST_IDX = 6'(W_BITS - 1);
  localparam logic [5:0] C_NUM_DATA = 6'(D_BITS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // H-matrix column for codeword bit idx. Data columns are the weight-3
  // bytes in ascending order; check columns are the unit vectors.
  function automatic logic [C_CHK_BITS-1:0] h_col(input logic [5:0] idx);
    logic [C_CHK_BITS-1:0] h;
    case (idx)
      6'd0:  h = 8'h07;  6'd1:  h = 8'h0B;  6'd2:  h = 8'h0D;  6'd3:  h = 8'h0E;
      6'd4:  h = 8'h13;  6'd5:  h = 8'h15;  6'd6:  h = 8'h16;  6'd7:  h = 8'h19;
      6'd8:  h = 8'h1A;  6'd9:  h = 8'h1C;  6'd10: h = 8'h23;  6'd11: h = 8'h25;
      6'd12: h = 8'h26;  6'd13: h = 8'h29;  6'd14: h = 8'h2A;  6'd15: h = 8'h2C;
      6'd16: h = 8'h31;  6'd17: h = 8'h32;  6'd18: h = 8'h34;  6'd19: h = 8'h38;
      6'd20: h = 8'h43;  6'd21: h = 8'h45;  6'd22: h = 8'h46;  6'd23: h = 8'h49;
      6'd24: h = 8'h4A;  6'd25: h = 8'h4C;  6'd26: h = 8'h51;  6'd27: h = 8'h52;
      6'd28: h = 8'h01;  6'd29: h = 8'h02;  6'd30: h = 8'h04;  6'd31: h = 8'h08;
      6'd32: h = 8'h10;  6'd33: h = 8'h20;  6'd34: h = 8'h40;  6'd35: h = 8'h80;
      default: h = 8'h00;
    endcase
    return h;
  endfunction

  // Syndrome = received check bits XOR recomputed check bits.
  function automatic logic [C_CHK_BITS-1:0] syndrome(input logic [W_BITS-1:0] cw);
    logic [C_CHK_BITS-1:0] s;
    s = cw[W_BITS-1:D_BITS];
    for (int j = 0; j < D_BITS; j++) begin
      if (cw[j]) s = s ^ h_col(6'(j));
    end
    return s;
  endfunction

  state_t                r_state;
  logic [W_BITS-1:0]     r_w_q;
  logic [C_CHK_BITS-1:0] r_s;
  logic [5:0]            r_idx;

  logic                  w_load;
  logic                  w_match;
  logic [D_BITS-1:0]     w_flip_mask;
  logic [D_BITS-1:0]     w_corrected;

  // An X on W makes the compare X, which takes no load branch.
  assign w_load      = (W != r_w_q);
  assign w_match     = (r_s == h_col(r_idx));
  // A matching check-bit column leaves the data unchanged.
  assign w_flip_mask = (r_idx < C_NUM_DATA) ? (D_BITS'(1) << r_idx) : '0;
  assign w_corrected = r_w_q[D_BITS-1:0] ^ w_flip_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_w_q   <= '0;
      r_s     <= '0;
      r_idx   <= '0;
      found   <= 1'b0;
      N       <= '0;
    end else if (w_load) begin
      // Load takes priority in every state: a new word aborts any search.
      r_w_q   <= W;
      r_s     <= syndrome(W);
      r_idx   <= '0;
      found   <= 1'b0;
      N       <= '0;
      r_state <= ST_SEARCH;
    end else begin
      case (r_state)
        ST_SEARCH: begin
          if (r_s == '0) begin
            N       <= {1'b0, r_w_q[D_BITS-1:0]};
            found   <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_match) begin
            N       <= {1'b0, w_corrected};
            found   <= 1'b1;
            r_state <= ST_DONE;
          end else if (r_idx == C_LAST_IDX) begin
            // No single-bit column matches: even weight or unused syndrome.
            N       <= {1'b1, r_w_q[D_BITS-1:0]};
            found   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx + 6'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sec_decoder_awe_28b_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sec_decoder_awe_28b_seq
//  Purpose  : Self-checking bench for sec_decoder_awe_28b_seq. Directed cases
//             plus random codewords with 0/1/2 injected errors or garbage,
//             checked against a table-driven decoder model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sec_decoder_awe_28b_seq;

  logic        clk;
  logic        rst_n;
  logic [35:0] w;
  logic        found;
  logic [28:0] n;

  int          n_cmp;
  int          n_bad;
  logic [7:0]  hcol [36];

  sec_decoder_awe_28b_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .W     (w),
    .found (found),
    .N     (n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decoder: returns the expected latency (edges after load) and N.
  function automatic void model(input logic [35:0] cw, output int lat, output logic [28:0] res);
    logic [7:0] s;
    int         k;
    s = cw[35:28];
    for (int j = 0; j < 28; j++) if (cw[j]) s ^= hcol[j];
    k = -1;
    for (int i = 35; i >= 0; i--) if (hcol[i] == s) k = i;
    if (s == 8'h00) begin
      lat = 1;
      res = {1'b0, cw[27:0]};
    end else if (k >= 0) begin
      lat = k + 1;
      res = {1'b0, cw[27:0]};
      if (k < 28) res[k] = ~res[k];
    end else begin
      lat = 36;
      res = {1'b1, cw[27:0]};
    end
  endfunction

  function automatic logic [35:0] encode(input logic [27:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int j = 0; j < 28; j++) if (d[j]) c ^= hcol[j];
    return {c, d};
  endfunction

  // Called at a negedge with W already presenting a new word: the next
  // posedge is the load edge. Measures latency and final N.
  task automatic measure(input string tag);
    int          exp_lat;
    int          obs_lat;
    logic [28:0] exp_n;
    model(w, exp_lat, exp_n);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_found_cleared"}, {63'd0, found}, 64'd0);
    obs_lat = 99;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (found === 1'b1) begin
        obs_lat = c;
        break;
      end
    end
    check({tag, "_latency"}, 64'(obs_lat), 64'(exp_lat));
    check({tag, "_N"}, {35'd0, n}, {35'd0, exp_n});
  endtask

  task automatic apply(input logic [35:0] v, input string tag);
    @(negedge clk);
    w = v;
    measure(tag);
  endtask

  initial begin
    logic [35:0] v;
    logic [35:0] last;
    int          kind;
    int          b0;
    int          b1;
    int          cnt;

    n_cmp = 0;
    n_bad = 0;
    cnt   = 0;
    for (int v8 = 0; v8 < 256; v8++) begin
      if ($countones(8'(v8)) == 3 && cnt < 28) begin
        hcol[cnt] = 8'(v8);
        cnt++;
      end
    end
    for (int i = 0; i < 8; i++) hcol[28 + i] = 8'(1 << i);

    rst_n = 1'b0;
    w     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_found", {63'd0, found}, 64'd0);
    check("reset_N", {35'd0, n}, 64'd0);
    rst_n = 1'b1;
    // W=0 equals the reset W_q: no load, nothing happens.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_zero_no_load", {63'd0, found}, 64'd0);

    apply(36'h0CFFFFFFF, "clean");
    check("clean_const_N", {35'd0, n}, 64'h0FFFFFFF);
    apply(36'h0CFFFFFFE, "data0");
    check("data0_const_N", {35'd0, n}, 64'h0FFFFFFF);
    apply(36'h0C7FFFFFF, "data27");
    apply(36'h8CFFFFFFF, "chk35");
    check("chk35_const_N", {35'd0, n}, 64'h0FFFFFFF);
    apply(36'h0CFFFFFFC, "double01");
    check("double01_const_N", {35'd0, n}, 64'h1FFFFFFC);

    // DONE holds while W is held.
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("done_hold_found", {63'd0, found}, 64'd1);
    check("done_hold_N", {35'd0, n}, 64'h1FFFFFFC);

    last = 36'h0CFFFFFFC;
    for (int t = 0; t < 40; t++) begin
      v    = encode(28'($urandom));
      kind = $urandom_range(0, 3);
      b0   = $urandom_range(0, 35);
      b1   = (b0 + $urandom_range(1, 35)) % 36;
      if (kind == 1) v[b0] = ~v[b0];
      if (kind == 2) begin
        v[b0] = ~v[b0];
        v[b1] = ~v[b1];
      end
      if (kind == 3) v = {4'($urandom), 32'($urandom)};
      if (v == last) v[5] = ~v[5];
      last = v;
      apply(v, "rand");
    end

    // Abort mid-search: new word replaces the one being searched.
    @(negedge clk);
    w = 36'h8CFFFFFFF;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("abort_midsearch_found", {63'd0, found}, 64'd0);
    w = encode(28'h1234567) ^ 36'h000000100;
    measure("abort_new");

    // Async reset in DONE: outputs clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_done_found", {63'd0, found}, 64'd0);
    check("async_rst_done_N", {35'd0, n}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    w     = 36'h0C7FFFFFF;
    measure("post_rst");

    // Async reset mid-search, then release with W held: W != 0 reloads.
    @(negedge clk);
    w = 36'h0CFFFFFFC;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_search_found", {63'd0, found}, 64'd0);
    check("async_rst_search_N", {35'd0, n}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    measure("reload_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
